// File: rtl/simple_mem_arbiter.sv
// Single-port RAM arbiter for the SIMPLE processor: shares one RAM port between
// fetch (f), load/store (d) and debug/loader (x), sequencing reads through a latency wait.
module simple_mem_arbiter #(
  parameter int AW     = 16,
  parameter int DW     = 16,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          f_req,
  input  logic [AW-1:0] f_addr,
  output logic          f_gnt,
  output logic          f_rvalid,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  input  logic          x_req,
  input  logic          x_we,
  input  logic [AW-1:0] x_addr,
  input  logic [DW-1:0] x_wdata,
  output logic          x_gnt,
  output logic          x_rvalid,
  output logic [DW-1:0] rdata,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_wren,
  input  logic [DW-1:0] mem_q,
  output logic          busy
);

  typedef enum logic {S_IDLE, S_RDWAIT} state_t;
  localparam int CW = 2;

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [AW-1:0] r_addr, w_addr_nxt;
  logic [2:0]    r_own, w_own_nxt;   // one-hot read owner {x, d, f}
  logic          r_fav_x, w_fav_x_nxt;

  logic          w_gnt_f, w_gnt_d, w_gnt_x;
  logic [AW-1:0] w_mem_addr;
  logic [DW-1:0] w_mem_wdata;
  logic          w_mem_wren;
  logic          w_rv_f, w_rv_d, w_rv_x;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_own   <= '0;
      r_fav_x <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_addr  <= w_addr_nxt;
      r_own   <= w_own_nxt;
      r_fav_x <= w_fav_x_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_addr_nxt  = r_addr;
    w_own_nxt   = r_own;
    w_fav_x_nxt = r_fav_x;
    w_gnt_f     = 1'b0;
    w_gnt_d     = 1'b0;
    w_gnt_x     = 1'b0;
    w_rv_f      = 1'b0;
    w_rv_d      = 1'b0;
    w_rv_x      = 1'b0;
    w_mem_addr  = f_addr;
    w_mem_wdata = d_wdata;
    w_mem_wren  = 1'b0;
    case (r_state)
      S_IDLE: begin
        // d always first; x/f contention resolved by the fairness bit
        if (d_req)                            w_gnt_d = 1'b1;
        else if (x_req && (!f_req || r_fav_x)) w_gnt_x = 1'b1;
        else if (f_req)                        w_gnt_f = 1'b1;

        if (w_gnt_d) begin
          w_mem_addr  = d_addr;
          w_mem_wdata = d_wdata;
          w_mem_wren  = d_we;
        end else if (w_gnt_x) begin
          w_mem_addr  = x_addr;
          w_mem_wdata = x_wdata;
          w_mem_wren  = x_we;
        end

        if (w_gnt_x) w_fav_x_nxt = 1'b0;
        if (w_gnt_f) w_fav_x_nxt = 1'b1;

        if ((w_gnt_d || w_gnt_x || w_gnt_f) && !w_mem_wren) begin
          w_state_nxt = S_RDWAIT;
          w_cnt_nxt   = CW'(RD_LAT);
          w_addr_nxt  = w_mem_addr;
          w_own_nxt   = {w_gnt_x, w_gnt_d, w_gnt_f};
        end
      end
      S_RDWAIT: begin
        w_mem_addr = r_addr;
        w_cnt_nxt  = r_cnt - CW'(1);
        if (r_cnt == CW'(1)) begin
          w_rv_f      = r_own[0];
          w_rv_d      = r_own[1];
          w_rv_x      = r_own[2];
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign f_gnt     = w_gnt_f;
  assign d_gnt     = w_gnt_d;
  assign x_gnt     = w_gnt_x;
  assign f_rvalid  = w_rv_f;
  assign d_rvalid  = w_rv_d;
  assign x_rvalid  = w_rv_x;
  assign rdata     = mem_q;
  assign mem_addr  = w_mem_addr;
  assign mem_wdata = w_mem_wdata;
  assign mem_wren  = w_mem_wren;
  assign busy      = (r_state == S_RDWAIT);

endmodule

// File: tb/tb_simple_mem_arbiter.sv
// Bench for simple_mem_arbiter: directed scenarios plus random traffic, checked against
// a timestamp/queue reference model of the arbitration rules and a behavioural RAM.
module tb_simple_mem_arbiter;
  localparam int AW = 16, DW = 16, RD_LAT = 2, P = RD_LAT + 1;

  logic clk = 1'b0, reset = 1'b0;
  logic f_req = 0, d_req = 0, d_we = 0, x_req = 0, x_we = 0;
  logic [AW-1:0] f_addr = '0, d_addr = '0, x_addr = '0;
  logic [DW-1:0] d_wdata = '0, x_wdata = '0;
  logic f_gnt, f_rvalid, d_gnt, d_rvalid, x_gnt, x_rvalid, mem_wren, busy;
  logic [DW-1:0] rdata, mem_wdata, mem_q;
  logic [AW-1:0] mem_addr;

  int n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  simple_mem_arbiter #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .reset(reset),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt), .d_rvalid(d_rvalid),
    .x_req(x_req), .x_we(x_we), .x_addr(x_addr), .x_wdata(x_wdata), .x_gnt(x_gnt), .x_rvalid(x_rvalid),
    .rdata(rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wren(mem_wren),
    .mem_q(mem_q), .busy(busy));

  function automatic logic [DW-1:0] ram_init(input logic [AW-1:0] a);
    logic [DW-1:0] v;
    v = DW'(a * 16'h9E37 + 16'h1357);
    return (a == 16'h0010) ? 16'hA5A5 : v;
  endfunction

  // Behavioural RAM attached to the DUT, with an RD_LAT-deep read pipe
  logic [DW-1:0] ram [0:(1<<AW)-1];
  bit            ram_wr [0:(1<<AW)-1];
  logic [DW-1:0] q_pipe [RD_LAT];
  function automatic logic [DW-1:0] env_rd(input logic [AW-1:0] a);
    return ram_wr[a] ? ram[a] : ram_init(a);
  endfunction
  always @(posedge clk) begin
    if (mem_wren) begin
      ram[mem_addr]    <= mem_wdata;
      ram_wr[mem_addr] <= 1'b1;
    end
    q_pipe[0] <= env_rd(mem_addr);
    for (int i = 1; i < RD_LAT; i++) q_pipe[i] <= q_pipe[i-1];
  end
  assign mem_q = q_pipe[RD_LAT-1];

  // Reference model: port is busy until free_at; pending reads wait in a due-cycle queue
  typedef struct { int due; int port; logic [DW-1:0] data; } rd_t;
  rd_t rq[$];
  int  cyc = 0, free_at = 0;
  bit  fav_x = 1'b0;
  logic [AW-1:0] m_raddr = '0;
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  bit            ref_wr  [0:(1<<AW)-1];

  function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
    return ref_wr[a] ? ref_mem[a] : ram_init(a);
  endfunction

  // 0 none, 1 f, 2 d, 3 x
  function automatic int pick();
    if (cyc < free_at) return 0;
    if (d_req) return 2;
    if (x_req && f_req) return fav_x ? 3 : 1;
    if (x_req) return 3;
    if (f_req) return 1;
    return 0;
  endfunction

  always @(posedge clk or posedge reset) begin : model
    int w;
    logic [AW-1:0] a;
    if (reset) begin
      cyc <= 0; free_at <= 0; fav_x <= 1'b0;
      rq.delete();
    end else begin
      w = pick();
      a = (w == 2) ? d_addr : (w == 3) ? x_addr : f_addr;
      cyc <= cyc + 1;
      if (rq.size() > 0 && rq[0].due == cyc) void'(rq.pop_front());
      if (w == 1 || w == 3) fav_x <= (w == 1);
      if ((w == 2 && d_we) || (w == 3 && x_we)) begin
        ref_mem[a] <= (w == 2) ? d_wdata : x_wdata;
        ref_wr[a]  <= 1'b1;
      end else if (w != 0) begin
        rq.push_back('{cyc + RD_LAT, w, ref_rd(a)});
        free_at <= cyc + RD_LAT + 1;
        m_raddr <= a;
      end
    end
  end

  logic e_fg, e_dg, e_xg, e_fv, e_dv, e_xv, e_busy, e_wren;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wdata, e_rdata;
  function automatic void eval();
    int w;
    w = pick();
    e_fg = (w == 1); e_dg = (w == 2); e_xg = (w == 3);
    e_busy = (cyc < free_at);
    e_wren = (w == 2 && d_we) || (w == 3 && x_we);
    e_addr = (w == 2) ? d_addr : (w == 3) ? x_addr : (w == 1) ? f_addr : e_busy ? m_raddr : f_addr;
    e_wdata = (w == 2) ? d_wdata : x_wdata;
    {e_fv, e_dv, e_xv} = 3'b000;
    e_rdata = '0;
    if (rq.size() > 0 && rq[0].due == cyc) begin
      e_fv = (rq[0].port == 1); e_dv = (rq[0].port == 2); e_xv = (rq[0].port == 3);
      e_rdata = rq[0].data;
    end
  endfunction

  task automatic next();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; f_addr = 16'h0BEE;
    @(negedge clk);
    n_chk++; if ({f_gnt, d_gnt, x_gnt} !== 3'b000) begin n_fail++; $display("FAIL reset_gnt: got %b want 000", {f_gnt, d_gnt, x_gnt}); end
    n_chk++; if ({f_rvalid, d_rvalid, x_rvalid} !== 3'b000) begin n_fail++; $display("FAIL reset_rvalid: got %b want 000", {f_rvalid, d_rvalid, x_rvalid}); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_chk++; if (mem_wren !== 1'b0) begin n_fail++; $display("FAIL reset_wren: got %b want 0", mem_wren); end
    n_chk++; if (mem_addr !== 16'h0BEE) begin n_fail++; $display("FAIL reset_addr: got %h want 0bee", mem_addr); end
    next(); reset = 1'b0;
  endtask

  task automatic test_fetch_read();
    f_req = 1; f_addr = 16'h0010;
    @(negedge clk);
    n_chk++; if (f_gnt !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL fetch_gnt: got gnt=%b busy=%b want 1 0", f_gnt, busy); end
    n_chk++; if (mem_addr !== 16'h0010) begin n_fail++; $display("FAIL fetch_addr: got %h want 0010", mem_addr); end
    next(); f_req = 0;
    for (int k = 1; k <= RD_LAT; k++) begin
      @(negedge clk);
      n_chk++; if (busy !== 1'b1 || f_rvalid !== (k == RD_LAT)) begin n_fail++; $display("FAIL fetch_wait%0d: got busy=%b rv=%b", k, busy, f_rvalid); end
      if (k == RD_LAT) begin
        n_chk++; if (rdata !== 16'hA5A5) begin n_fail++; $display("FAIL fetch_rdata: got %h want a5a5", rdata); end
      end
      next();
    end
    @(negedge clk);
    n_chk++; if (busy !== 1'b0 || f_rvalid !== 1'b0) begin n_fail++; $display("FAIL fetch_done: got busy=%b rv=%b want 0 0", busy, f_rvalid); end
    next();
  endtask

  task automatic test_write_then_read();
    d_req = 1; d_we = 1; d_addr = 16'h0020; d_wdata = 16'h1234; f_req = 1; f_addr = 16'h0030;
    @(negedge clk);
    n_chk++; if (d_gnt !== 1'b1 || f_gnt !== 1'b0 || mem_wren !== 1'b1) begin n_fail++; $display("FAIL wr_gnt: got d=%b f=%b wren=%b want 1 0 1", d_gnt, f_gnt, mem_wren); end
    n_chk++; if (mem_addr !== 16'h0020 || mem_wdata !== 16'h1234) begin n_fail++; $display("FAIL wr_bus: got %h/%h want 0020/1234", mem_addr, mem_wdata); end
    next(); d_req = 0; d_we = 0;
    @(negedge clk);
    n_chk++; if (f_gnt !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL wr_next_fgnt: got f=%b busy=%b want 1 0", f_gnt, busy); end
    next(); f_req = 0;
    repeat (RD_LAT) next();
    d_req = 1; d_addr = 16'h0020;
    @(negedge clk);
    n_chk++; if (d_gnt !== 1'b1) begin n_fail++; $display("FAIL rd_back_gnt: got %b want 1", d_gnt); end
    next(); d_req = 0;
    repeat (RD_LAT - 1) next();
    @(negedge clk);
    n_chk++; if (d_rvalid !== 1'b1 || rdata !== 16'h1234) begin n_fail++; $display("FAIL rd_back: got rv=%b data=%h want 1 1234", d_rvalid, rdata); end
    next();
  endtask

  task automatic test_alternate();
    logic prev_f, port_f;
    logic [DW-1:0] want;
    prev_f = 0; port_f = 0; want = '0;
    f_req = 1; f_addr = 16'h0040; x_req = 1; x_we = 0; x_addr = 16'h0050;
    for (int i = 0; i < 4 * P; i++) begin
      @(negedge clk);
      n_chk++; if ((f_gnt | x_gnt) !== (i % P == 0)) begin n_fail++; $display("FAIL alt_spacing%0d: got %b want %b", i, f_gnt | x_gnt, i % P == 0); end
      if (i % P == 0) begin
        if (i > 0) begin
          n_chk++; if (f_gnt === prev_f) begin n_fail++; $display("FAIL alt_order%0d: got f_gnt=%b twice", i, f_gnt); end
        end
        prev_f = f_gnt; port_f = f_gnt;
        want = ref_rd(f_gnt ? f_addr : x_addr);
      end
      if (i % P == RD_LAT) begin
        n_chk++; if ((port_f ? f_rvalid : x_rvalid) !== 1'b1 || rdata !== want) begin n_fail++; $display("FAIL alt_rvalid%0d: got rv=%b data=%h want 1 %h", i, port_f ? f_rvalid : x_rvalid, rdata, want); end
      end
      next();
    end
    f_req = 0; x_req = 0;
  endtask

  task automatic test_d_during_x();
    x_req = 1; x_we = 0; x_addr = 16'h0060;
    @(negedge clk);
    n_chk++; if (x_gnt !== 1'b1) begin n_fail++; $display("FAIL dx_xgnt: got %b want 1", x_gnt); end
    next(); x_req = 0; d_req = 1; d_we = 0; d_addr = 16'h0070; f_req = 1; f_addr = 16'h0080;
    for (int k = 1; k <= RD_LAT; k++) begin
      @(negedge clk);
      n_chk++; if (d_gnt !== 1'b0 || x_rvalid !== (k == RD_LAT)) begin n_fail++; $display("FAIL dx_wait%0d: got dgnt=%b xrv=%b", k, d_gnt, x_rvalid); end
      next();
    end
    @(negedge clk);
    n_chk++; if (d_gnt !== 1'b1 || f_gnt !== 1'b0) begin n_fail++; $display("FAIL dx_dwins: got d=%b f=%b want 1 0", d_gnt, f_gnt); end
    next(); d_req = 0; f_req = 0;
    repeat (RD_LAT - 1) next();
    @(negedge clk);
    n_chk++; if (d_rvalid !== 1'b1 || rdata !== ref_rd(16'h0070)) begin n_fail++; $display("FAIL dx_drdata: got rv=%b data=%h want 1 %h", d_rvalid, rdata, ref_rd(16'h0070)); end
    next();
  endtask

  task automatic test_reset_midread();
    d_req = 1; d_we = 0; d_addr = 16'h0090;
    @(negedge clk);
    n_chk++; if (d_gnt !== 1'b1) begin n_fail++; $display("FAIL rst_dgnt: got %b want 1", d_gnt); end
    next(); d_req = 0; reset = 1;
    @(negedge clk);
    n_chk++; if (busy !== 1'b0 || d_rvalid !== 1'b0) begin n_fail++; $display("FAIL rst_abort: got busy=%b rv=%b want 0 0", busy, d_rvalid); end
    next(); reset = 0; f_req = 1; f_addr = 16'h00A0;
    for (int k = 0; k <= RD_LAT + 1; k++) begin
      @(negedge clk);
      if (k == 0) begin
        n_chk++; if (f_gnt !== 1'b1) begin n_fail++; $display("FAIL rst_fgnt: got %b want 1", f_gnt); end
      end
      n_chk++; if (d_rvalid !== 1'b0) begin n_fail++; $display("FAIL rst_no_drv%0d: got %b want 0", k, d_rvalid); end
      next(); f_req = 0;
    end
  endtask

  task automatic test_cancel();
    d_req = 1; d_we = 0; d_addr = 16'h00B0;
    @(negedge clk);
    next(); d_req = 0; x_req = 1; x_we = 1; x_addr = 16'h00C0; x_wdata = 16'hDEAD;
    for (int k = 1; k <= RD_LAT + 2; k++) begin
      @(negedge clk);
      n_chk++; if (x_gnt !== 1'b0 || mem_wren !== 1'b0) begin n_fail++; $display("FAIL cancel%0d: got xgnt=%b wren=%b want 0 0", k, x_gnt, mem_wren); end
      next();
      if (k == RD_LAT) x_req = 0;
    end
    x_we = 0;
    n_chk++; if (env_rd(16'h00C0) !== ram_init(16'h00C0)) begin n_fail++; $display("FAIL cancel_ram: got %h want %h", env_rd(16'h00C0), ram_init(16'h00C0)); end
  endtask

  task automatic test_random();
    logic sf, sd, sx;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      eval();
      n_chk++; if ({f_gnt, d_gnt, x_gnt} !== {e_fg, e_dg, e_xg}) begin n_fail++; $display("FAIL rnd_gnt@%0d: got %b want %b", i, {f_gnt, d_gnt, x_gnt}, {e_fg, e_dg, e_xg}); end
      n_chk++; if ({f_rvalid, d_rvalid, x_rvalid} !== {e_fv, e_dv, e_xv}) begin n_fail++; $display("FAIL rnd_rvalid@%0d: got %b want %b", i, {f_rvalid, d_rvalid, x_rvalid}, {e_fv, e_dv, e_xv}); end
      n_chk++; if (busy !== e_busy || mem_wren !== e_wren || mem_addr !== e_addr) begin n_fail++; $display("FAIL rnd_bus@%0d: got busy=%b wren=%b addr=%h want %b %b %h", i, busy, mem_wren, mem_addr, e_busy, e_wren, e_addr); end
      if (e_wren) begin
        n_chk++; if (mem_wdata !== e_wdata) begin n_fail++; $display("FAIL rnd_wdata@%0d: got %h want %h", i, mem_wdata, e_wdata); end
      end
      if (e_fv | e_dv | e_xv) begin
        n_chk++; if (rdata !== e_rdata) begin n_fail++; $display("FAIL rnd_rdata@%0d: got %h want %h", i, rdata, e_rdata); end
      end
      sf = f_gnt; sd = d_gnt; sx = x_gnt;
      next();
      if (sf) f_req = 0;
      if (sd) d_req = 0;
      if (sx) x_req = 0;
      if (!f_req) begin f_addr = AW'($urandom_range(0, 15)); f_req = ($urandom_range(0, 2) == 0); end
      else if ($urandom_range(0, 15) == 0) f_req = 0;
      if (!d_req) begin
        d_addr = AW'($urandom_range(0, 15)); d_we = 1'($urandom_range(0, 1));
        d_wdata = DW'($urandom); d_req = ($urandom_range(0, 3) == 0);
      end else if ($urandom_range(0, 15) == 0) d_req = 0;
      if (!x_req) begin
        x_addr = AW'($urandom_range(0, 15)); x_we = 1'($urandom_range(0, 1));
        x_wdata = DW'($urandom); x_req = ($urandom_range(0, 2) == 0);
      end else if ($urandom_range(0, 15) == 0) x_req = 0;
    end
    f_req = 0; d_req = 0; x_req = 0;
    repeat (P) next();
  endtask

  initial begin
    test_reset();
    test_fetch_read();
    test_write_then_read();
    test_alternate();
    test_d_during_x();
    test_reset_midread();
    test_cancel();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
